// File: rtl/tc_tl_mem_responder.sv
// tc_tl_mem_responder: TileLink uncached manager serving Get/GetBlock/Put/PutBlock from a data+tag array
// and retiring manager transaction ids on Finish.
module tc_tl_mem_responder #(
    parameter int TLAW  = 32,
    parameter int TLDW  = 64,
    parameter int TLTW  = 4,
    parameter int TLBS  = 8,
    parameter int TLCIS = 7,
    parameter int TLMIS = 2,
    parameter int NBLK  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_acquire_valid,
    output logic             io_in_acquire_ready,
    input  logic [TLAW-7:0]  io_in_acquire_bits_addr_block,
    input  logic [TLCIS-1:0] io_in_acquire_bits_client_xact_id,
    input  logic             io_in_acquire_bits_client_id,
    input  logic [2:0]       io_in_acquire_bits_addr_beat,
    input  logic             io_in_acquire_bits_is_builtin_type,
    input  logic [2:0]       io_in_acquire_bits_a_type,
    input  logic [12:0]      io_in_acquire_bits_union,
    input  logic [TLDW-1:0]  io_in_acquire_bits_data,
    input  logic [TLTW-1:0]  io_in_acquire_bits_tag,
    input  logic             io_in_grant_ready,
    output logic             io_in_grant_valid,
    output logic [TLCIS-1:0] io_in_grant_bits_client_xact_id,
    output logic             io_in_grant_bits_client_id,
    output logic [2:0]       io_in_grant_bits_addr_beat,
    output logic [TLMIS-1:0] io_in_grant_bits_manager_xact_id,
    output logic             io_in_grant_bits_is_builtin_type,
    output logic [3:0]       io_in_grant_bits_g_type,
    output logic [TLDW-1:0]  io_in_grant_bits_data,
    output logic [TLTW-1:0]  io_in_grant_bits_tag,
    input  logic             io_in_finish_valid,
    output logic             io_in_finish_ready,
    input  logic [TLMIS-1:0] io_in_finish_bits_manager_xact_id,
    output logic             err
);
    localparam int IW = $clog2(NBLK);
    localparam int AW = IW + 3;
    localparam int NID = 1 << TLMIS;
    localparam logic [2:0] LAST = 3'(TLBS - 1);
    localparam logic [3:0] G_PUT = 4'd3;
    localparam logic [3:0] G_BEAT = 4'd4;
    localparam logic [3:0] G_BLOCK = 4'd5;

    typedef enum logic [1:0] {IDLE, PWR, GRANT} state_t;

    state_t           state, state_nx;
    logic [NID-1:0]   busy, sent;
    logic [TLMIS-1:0] alloc;
    logic [TLAW-7:0]  cur_blk;
    logic [2:0]       cur_beat;
    logic [3:0]       cur_gt;
    logic             cur_blk_rd;
    logic [TLCIS-1:0] cur_cxid;
    logic             cur_cid;
    logic [TLMIS-1:0] cur_mid;
    logic [TLDW-1:0]  data_mem [NBLK*TLBS];
    logic [TLTW-1:0]  tag_mem [NBLK*TLBS];
    logic [TLDW-1:0]  rd_data;
    logic [TLTW-1:0]  rd_tag;
    logic [7:0]       mask;
    logic             legal, is_put, is_pblk, last;
    logic             g_fire, g_last_fire, can_take, a_fire, new_acq, pwr_fire, pwr_last, pwr_bad;
    logic             fin_fire, fin_bad, we, re;
    logic [AW-1:0]    wa, ra;

    // Lowest free id is taken from the pool as it stood at the start of the cycle.
    always_comb begin
        alloc = '0;
        for (int i = NID - 1; i >= 0; i--)
            if (!busy[i]) alloc = TLMIS'(i);
    end

    assign mask        = io_in_acquire_bits_union[8:1];
    assign legal       = io_in_acquire_bits_is_builtin_type && !io_in_acquire_bits_a_type[2];
    assign is_put      = legal && io_in_acquire_bits_a_type[1];
    assign is_pblk     = legal && io_in_acquire_bits_a_type == 3'd3;
    assign last        = !cur_blk_rd || cur_beat == LAST;
    assign g_fire      = io_in_grant_valid && io_in_grant_ready;
    assign g_last_fire = state == GRANT && g_fire && last;
    // The final grant beat frees the FSM, so a waiting acquire may be taken in that same cycle.
    assign can_take    = state == IDLE || g_last_fire;
    assign io_in_acquire_ready = !reset && (state == PWR || (can_take && busy != '1));
    assign a_fire      = io_in_acquire_valid && io_in_acquire_ready;
    assign new_acq     = a_fire && state != PWR;
    assign pwr_fire    = a_fire && state == PWR;
    assign pwr_last    = pwr_fire && cur_beat == LAST;
    assign pwr_bad     = pwr_fire && (io_in_acquire_bits_addr_beat != cur_beat ||
                         io_in_acquire_bits_addr_block != cur_blk ||
                         io_in_acquire_bits_client_xact_id != cur_cxid);
    assign io_in_finish_ready = !reset;
    assign fin_fire    = io_in_finish_valid && io_in_finish_ready;
    assign fin_bad     = fin_fire && !(busy[io_in_finish_bits_manager_xact_id] &&
                         sent[io_in_finish_bits_manager_xact_id]);
    assign we = (new_acq && is_put) || pwr_fire;
    assign wa = pwr_fire ? {cur_blk[IW-1:0], cur_beat}
                         : {io_in_acquire_bits_addr_block[IW-1:0], is_pblk ? 3'd0 : io_in_acquire_bits_addr_beat};
    assign re = new_acq || (state == GRANT && g_fire && !last);
    assign ra = new_acq ? {io_in_acquire_bits_addr_block[IW-1:0],
                           (legal && io_in_acquire_bits_a_type == 3'd1) ? 3'd0 : io_in_acquire_bits_addr_beat}
                        : {cur_blk[IW-1:0], cur_beat + 3'd1};

    always_comb begin
        state_nx = new_acq ? (is_pblk ? PWR : GRANT) : pwr_last ? GRANT : g_last_fire ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= '0;
            sent  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err | (new_acq && !legal) | pwr_bad | fin_bad;
            if (fin_fire && !fin_bad) begin
                busy[io_in_finish_bits_manager_xact_id] <= 1'b0;
                sent[io_in_finish_bits_manager_xact_id] <= 1'b0;
            end
            if (new_acq) begin
                busy[alloc] <= 1'b1;
                sent[alloc] <= 1'b0;
            end
            if (g_last_fire) sent[cur_mid] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (new_acq) begin
            cur_blk    <= io_in_acquire_bits_addr_block;
            cur_cxid   <= io_in_acquire_bits_client_xact_id;
            cur_cid    <= io_in_acquire_bits_client_id;
            cur_mid    <= alloc;
            cur_blk_rd <= legal && io_in_acquire_bits_a_type == 3'd1;
            cur_gt     <= (!legal || io_in_acquire_bits_a_type[1]) ? G_PUT :
                          io_in_acquire_bits_a_type[0] ? G_BLOCK : G_BEAT;
            cur_beat   <= is_pblk ? 3'd1 : (legal && io_in_acquire_bits_a_type == 3'd0) ?
                          io_in_acquire_bits_addr_beat : 3'd0;
        end else if (pwr_fire) begin
            cur_beat <= pwr_last ? 3'd0 : cur_beat + 3'd1;
        end else if (re) begin
            cur_beat <= cur_beat + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < TLDW / 8; b++)
                if (mask[b]) data_mem[wa][b*8 +: 8] <= io_in_acquire_bits_data[b*8 +: 8];
            if (mask != '0) tag_mem[wa] <= io_in_acquire_bits_tag;
        end
        if (re) begin
            rd_data <= data_mem[ra];
            rd_tag  <= tag_mem[ra];
        end
    end

    assign io_in_grant_valid                = state == GRANT;
    assign io_in_grant_bits_client_xact_id  = cur_cxid;
    assign io_in_grant_bits_client_id       = cur_cid;
    assign io_in_grant_bits_addr_beat       = cur_beat;
    assign io_in_grant_bits_manager_xact_id = cur_mid;
    assign io_in_grant_bits_is_builtin_type = 1'b1;
    assign io_in_grant_bits_g_type          = cur_gt;
    assign io_in_grant_bits_data            = cur_gt == G_PUT ? '0 : rd_data;
    assign io_in_grant_bits_tag             = cur_gt == G_PUT ? '0 : rd_tag;
endmodule

// File: tb/tb_tc_tl_mem_responder.sv
// tb_tc_tl_mem_responder: directed bench with a transaction-level memory/pool model and a per-cycle grant checker.
module tb_tc_tl_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        acquire_valid, acquire_ready, client_id, builtin, grant_valid, finish_valid, finish_ready, err;
    logic [25:0] addr_block;
    logic [6:0]  cxid;
    logic [2:0]  addr_beat, a_type;
    logic [12:0] union_bits;
    logic [63:0] a_data;
    logic [3:0]  a_tag;
    logic        grant_ready = 1'b1;
    logic [6:0]  g_cxid;
    logic        g_cid, g_builtin;
    logic [2:0]  g_beat;
    logic [1:0]  g_mid, finish_id;
    logic [3:0]  g_type;
    logic [63:0] g_data;
    logic [3:0]  g_tag;

    tc_tl_mem_responder dut (
        .clk(clk), .reset(reset),
        .io_in_acquire_valid(acquire_valid), .io_in_acquire_ready(acquire_ready),
        .io_in_acquire_bits_addr_block(addr_block), .io_in_acquire_bits_client_xact_id(cxid),
        .io_in_acquire_bits_client_id(client_id), .io_in_acquire_bits_addr_beat(addr_beat),
        .io_in_acquire_bits_is_builtin_type(builtin), .io_in_acquire_bits_a_type(a_type),
        .io_in_acquire_bits_union(union_bits), .io_in_acquire_bits_data(a_data),
        .io_in_acquire_bits_tag(a_tag),
        .io_in_grant_ready(grant_ready), .io_in_grant_valid(grant_valid),
        .io_in_grant_bits_client_xact_id(g_cxid), .io_in_grant_bits_client_id(g_cid),
        .io_in_grant_bits_addr_beat(g_beat), .io_in_grant_bits_manager_xact_id(g_mid),
        .io_in_grant_bits_is_builtin_type(g_builtin), .io_in_grant_bits_g_type(g_type),
        .io_in_grant_bits_data(g_data), .io_in_grant_bits_tag(g_tag),
        .io_in_finish_valid(finish_valid), .io_in_finish_ready(finish_ready),
        .io_in_finish_bits_manager_xact_id(finish_id), .err(err)
    );

    typedef struct {
        logic [6:0]  cx;
        logic        cid;
        logic [1:0]  mid;
        logic [2:0]  beat;
        logic [3:0]  gt;
        logic [63:0] d;
        logic [3:0]  tg;
    } beat_t;

    beat_t       q[$];
    beat_t       e;
    logic [63:0] mdata [int];
    logic [3:0]  mtag [int];
    logic        mbusy [4];
    logic        merr;
    int          checks = 0, errors = 0, nbeats = 0, rdy_mode = 0;
    logic [63:0] last_data;
    logic [3:0]  last_tag, last_gt;
    logic [2:0]  last_beat;
    logic [1:0]  last_mid;
    logic        hold = 1'b0;
    logic [86:0] held;
    wire  [86:0] gvec = {grant_valid, g_cxid, g_cid, g_beat, g_mid, g_type, g_builtin, g_data, g_tag};

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // ready pattern: 0 always high, 1 toggling every cycle, 2 held low
    always @(posedge clk) begin
        #1;
        grant_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~grant_ready : 1'b0;
    end

    always @(negedge clk) begin
        if (reset) hold = 1'b0;
        else begin
            if (hold) chk("grant_hold", gvec, held);
            if (grant_valid && grant_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: got g_type %0d expected no grant", g_type);
                end else begin
                    e = q.pop_front();
                    chk("grant_fields", {g_cxid, g_cid, g_mid, g_beat, g_type, g_builtin},
                        {e.cx, e.cid, e.mid, e.beat, e.gt, 1'b1});
                    chk("grant_data", {g_data, g_tag}, {e.d, e.tg});
                    last_data = g_data;
                    last_tag  = g_tag;
                    last_gt   = g_type;
                    last_beat = g_beat;
                    last_mid  = g_mid;
                    nbeats++;
                end
            end
            hold = grant_valid && !grant_ready;
            held = gvec;
        end
    end

    function automatic int key(input logic [25:0] blk, input logic [2:0] b);
        return int'({blk[7:0], b});
    endfunction

    task automatic mwrite(input logic [25:0] blk, input logic [2:0] b, input logic [63:0] d,
                          input logic [3:0] tg, input logic [7:0] m);
        logic [63:0] v;
        v = mdata.exists(key(blk, b)) ? mdata[key(blk, b)] : 64'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) v[i*8 +: 8] = d[i*8 +: 8];
        mdata[key(blk, b)] = v;
        if (m != 8'd0) mtag[key(blk, b)] = tg;
    endtask

    task automatic m_alloc(output logic [1:0] id);
        logic found = 1'b0;
        id = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!mbusy[i]) begin
                id = 2'(i);
                found = 1'b1;
            end
        chk("model_pool_free", found, 1'b1);
        mbusy[id] = 1'b1;
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) mbusy[i] = 1'b0;
        merr = 1'b0;
    endtask

    task automatic set_acq(input logic [2:0] t, input logic [25:0] blk, input logic [2:0] b, input logic [6:0] cx,
                           input logic [63:0] d, input logic [3:0] tg, input logic [7:0] m, input logic bi);
        acquire_valid = 1'b1;
        a_type = t;
        addr_block = blk;
        addr_beat = b;
        cxid = cx;
        client_id = cx[0];
        a_data = d;
        a_tag = tg;
        union_bits = {4'd0, m, 1'b0};
        builtin = bi;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!acquire_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("acquire_accepted", acquire_ready, 1'b1);
    endtask

    task automatic model_single(input logic [2:0] t, input logic [25:0] blk, input logic [2:0] b, input logic [6:0] cx,
                                input logic [63:0] d, input logic [3:0] tg, input logic [7:0] m, input logic bi);
        logic  legal;
        beat_t x;
        legal = bi && t <= 3'd3;
        m_alloc(x.mid);
        x.cx = cx;
        x.cid = cx[0];
        if (!legal) merr = 1'b1;
        if (legal && t == 3'd2) mwrite(blk, b, d, tg, m);
        if (legal && t == 3'd0) begin
            x.beat = b;
            x.gt = 4'd4;
            x.d = mdata[key(blk, b)];
            x.tg = mtag[key(blk, b)];
            q.push_back(x);
        end else if (legal && t == 3'd1) begin
            for (int i = 0; i < 8; i++) begin
                x.beat = 3'(i);
                x.gt = 4'd5;
                x.d = mdata[key(blk, 3'(i))];
                x.tg = mtag[key(blk, 3'(i))];
                q.push_back(x);
            end
        end else begin
            x.beat = 3'd0;
            x.gt = 4'd3;
            x.d = 64'd0;
            x.tg = 4'd0;
            q.push_back(x);
        end
    endtask

    task automatic acq(input logic [2:0] t, input logic [25:0] blk, input logic [2:0] b, input logic [6:0] cx,
                       input logic [63:0] d, input logic [3:0] tg, input logic [7:0] m, input logic bi);
        set_acq(t, blk, b, cx, d, tg, m, bi);
        wait_ready();
        model_single(t, blk, b, cx, d, tg, m, bi);
        @(posedge clk);
        #1 acquire_valid = 1'b0;
    endtask

    // PutBlock beat i carries data i*mul and tag i; beat bad_at is sent with addr_beat bad_beat
    task automatic putblock(input logic [25:0] blk, input logic [6:0] cx, input logic [63:0] mul,
                            input int bad_at, input logic [2:0] bad_beat);
        beat_t x;
        for (int i = 0; i < 8; i++) begin
            set_acq(3'd3, blk, (i == bad_at) ? bad_beat : 3'(i), cx, mul * 64'(i), 4'(i), 8'hFF, 1'b1);
            wait_ready();
            if (i == 0) m_alloc(x.mid);
            if (i == bad_at && bad_beat != 3'(i)) merr = 1'b1;
            mwrite(blk, 3'(i), mul * 64'(i), 4'(i), 8'hFF);
            @(posedge clk);
            #1;
        end
        acquire_valid = 1'b0;
        x.cx = cx;
        x.cid = cx[0];
        x.beat = 3'd0;
        x.gt = 4'd3;
        x.d = 64'd0;
        x.tg = 4'd0;
        q.push_back(x);
    endtask

    task automatic fin(input logic [1:0] id);
        logic pending = 1'b0;
        finish_valid = 1'b1;
        finish_id = id;
        @(negedge clk);
        chk("finish_ready", finish_ready, 1'b1);
        foreach (q[i]) if (q[i].mid == id) pending = 1'b1;
        if (mbusy[id] && !pending) mbusy[id] = 1'b0;
        else merr = 1'b1;
        @(posedge clk);
        #1 finish_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("grants_drained", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_acquire_ready", acquire_ready, 1'b0);
        chk("rst_finish_ready", finish_ready, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_acquire_ready", acquire_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        acquire_valid = 1'b0;
        finish_valid = 1'b0;
        finish_id = 2'd0;
        set_acq(3'd0, 26'd0, 3'd0, 7'd0, 64'd0, 4'd0, 8'd0, 1'b1);
        acquire_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 do_reset();

        acq(3'd2, 26'h10, 3'd2, 7'h05, 64'hDEAD_BEEF, 4'h1, 8'hFF, 1'b1);
        drain();
        chk("put_ack_type", last_gt, 4'd3);
        chk("put_ack_id", last_mid, 2'd0);
        fin(2'd0);
        acq(3'd0, 26'h10, 3'd2, 7'h06, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        chk("get_data", last_data, 64'hDEAD_BEEF);
        chk("get_tag", last_tag, 4'h1);
        chk("get_beat", last_beat, 3'd2);
        chk("get_type", last_gt, 4'd4);
        fin(2'd0);

        putblock(26'h20, 7'h11, 64'h11, 8, 3'd0);
        drain();
        fin(2'd0);
        rdy_mode = 1;
        nbeats = 0;
        acq(3'd1, 26'h20, 3'd0, 7'h12, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        rdy_mode = 0;
        chk("getblock_beats", nbeats, 8);
        chk("getblock_last_data", last_data, 64'h77);
        chk("getblock_last_beat", last_beat, 3'd7);
        fin(2'd0);

        acq(3'd2, 26'h30, 3'd1, 7'h13, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 8'hFF, 1'b1);
        drain();
        fin(2'd0);
        acq(3'd2, 26'h30, 3'd1, 7'h14, 64'd0, 4'h3, 8'h0F, 1'b1);
        drain();
        fin(2'd0);
        acq(3'd0, 26'h30, 3'd1, 7'h15, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        chk("mask_data", last_data, 64'hFFFF_FFFF_0000_0000);
        chk("mask_tag", last_tag, 4'h3);
        fin(2'd0);

        for (int i = 0; i < 4; i++) begin
            acq(3'd0, 26'h10, 3'd2, 7'(8'h40 + i), 64'd0, 4'd0, 8'd0, 1'b1);
            drain();
        end
        set_acq(3'd0, 26'h10, 3'd2, 7'h44, 64'd0, 4'd0, 8'd0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("pool_stall", acquire_ready, 1'b0);
        end
        @(posedge clk);
        #1 fin(2'd2);
        wait_ready();
        model_single(3'd0, 26'h10, 3'd2, 7'h44, 64'd0, 4'd0, 8'd0, 1'b1);
        @(posedge clk);
        #1 acquire_valid = 1'b0;
        drain();
        chk("reuse_id", last_mid, 2'd2);
        fin(2'd0);
        fin(2'd1);
        fin(2'd3);
        fin(2'd2);

        fin(2'd3);
        @(negedge clk);
        chk("finish_free_err", err, merr);
        chk("finish_free_err_lit", err, 1'b1);
        @(posedge clk);
        #1 acq(3'd0, 26'h10, 3'd2, 7'h50, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        chk("pool_unchanged", last_mid, 2'd0);
        fin(2'd0);

        rdy_mode = 2;
        acq(3'd1, 26'h20, 3'd0, 7'h51, 64'd0, 4'd0, 8'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("getblock_waiting", grant_valid, 1'b1);
        @(posedge clk);
        #1 do_reset();
        rdy_mode = 0;

        acq(3'd5, 26'h10, 3'd2, 7'h21, 64'd0, 4'd0, 8'hFF, 1'b1);
        drain();
        chk("illegal_ack", last_gt, 4'd3);
        chk("illegal_err", err, merr);
        fin(2'd0);
        acq(3'd2, 26'h10, 3'd2, 7'h22, 64'd0, 4'd0, 8'hFF, 1'b0);
        drain();
        fin(2'd0);
        acq(3'd0, 26'h10, 3'd2, 7'h23, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        chk("illegal_no_write", last_data, 64'hDEAD_BEEF);
        fin(2'd0);

        do_reset();
        putblock(26'h40, 7'h31, 64'h0101, 3, 3'd5);
        drain();
        @(negedge clk);
        chk("pwr_order_err", err, merr);
        @(posedge clk);
        #1 fin(2'd0);
        acq(3'd1, 26'h40, 3'd0, 7'h32, 64'd0, 4'd0, 8'd0, 1'b1);
        drain();
        chk("pwr_last_data", last_data, 64'h0707);
        fin(2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
